// File: rtl/gate_sweep_checker_pkg.sv
// Shared types and constants for the gate sweep checker.
// State encoding plus reference truth tables for common two-input gates
// (bit i of a table = expected gate output for input vector i).
package gate_chk_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_SAMPLE = 2'd2,
    ST_DONE   = 2'd3
  } state_e;

  localparam logic [3:0] TT_OR2   = 4'b1110;
  localparam logic [3:0] TT_AND2  = 4'b1000;
  localparam logic [3:0] TT_XOR2  = 4'b0110;
  localparam logic [3:0] TT_NAND2 = 4'b0111;
  localparam logic [3:0] TT_NOR2  = 4'b0001;

endpackage

// File: rtl/gate_sweep_checker_if.sv
// Bundle between the sweep checker and its surroundings: the start request,
// the drive/sense pair towards the gate under test, and the result fields.
// master = checker side, slave = system / gate side.
interface gate_sweep_checker_if #(
  parameter int N_IN = 2
);
  import gate_chk_pkg::*;

  logic            start;
  logic [N_IN-1:0] dut_in;
  logic            dut_Y;
  logic            busy;
  logic            done;
  logic            pass;
  logic [N_IN:0]   err_count;
  logic [N_IN-1:0] fail_vec;

  modport master (
    input  start, dut_Y,
    output dut_in, busy, done, pass, err_count, fail_vec
  );

  modport slave (
    output start, dut_Y,
    input  dut_in, busy, done, pass, err_count, fail_vec
  );

endinterface

// File: rtl/gate_sweep_checker_settle_timer.sv
// Settle timer: loadable down-counter. A load arms it for SETTLE cycles of
// enable; expire_o is high during the last of those cycles.
module gate_chk_settle_timer #(
  parameter int SETTLE = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load_i,
  input  logic en_i,
  output logic expire_o
);

  localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [CW-1:0] LOAD_VAL = (SETTLE > 0) ? CW'(SETTLE - 1) : '0;

  logic [CW-1:0] cnt_q, cnt_d;

  // Next count: reload on request, otherwise count down towards zero while enabled.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = LOAD_VAL;
    end else if (en_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  // Count register.
  always_ff @(posedge clk) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign expire_o = en_i && (cnt_q == '0);

endmodule

// File: rtl/gate_sweep_checker.sv
// gate_sweep_checker: power-on self-check for a primitive gate. Walks every
// input vector, holds each SETTLE cycles, samples the gate output and compares
// it against EXP_TT. Reports pass, mismatch count and first failing vector.
// Optional macro GATE_CHK_STOP_ON_FAIL_EN: end the sweep at the first mismatch.
module gate_sweep_checker
  import gate_chk_pkg::*;
#(
  parameter int                  N_IN   = 2,
  parameter logic [2**N_IN-1:0]  EXP_TT = 4'b1110,
  parameter int                  SETTLE = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  gate_sweep_checker_if.master  chk
);

  localparam logic [N_IN-1:0] LAST_VEC = '1;

  state_e          state_q, state_d;
  logic [N_IN-1:0] vec_q, vec_d;
  logic [N_IN:0]   err_q, err_d;
  logic [N_IN-1:0] fail_q, fail_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            pass_q, pass_d;
  logic            mismatch;
  logic            finish;
  logic            tmr_load;
  logic            tmr_expire;

  assign mismatch = (chk.dut_Y != EXP_TT[vec_q]);

  // Arm the timer whenever a settle phase begins (new sweep or next vector).
  assign tmr_load = (state_d == ST_SETTLE) && (state_q != ST_SETTLE);

  gate_chk_settle_timer #(.SETTLE(SETTLE)) u_settle_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load_i   (tmr_load),
    .en_i     (state_q == ST_SETTLE),
    .expire_o (tmr_expire)
  );

  // Next state, vector counter and result fields.
  always_comb begin
    state_d = state_q;
    vec_d   = vec_q;
    err_d   = err_q;
    fail_d  = fail_q;
    busy_d  = busy_q;
    done_d  = done_q;
    pass_d  = pass_q;
    finish  = 1'b0;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (chk.start) begin
          err_d  = '0;
          fail_d = '0;
          pass_d = 1'b0;
          done_d = 1'b0;
          vec_d  = '0;
          busy_d = 1'b1;
          if (SETTLE == 0) state_d = ST_SAMPLE;
          else             state_d = ST_SETTLE;
        end
      end
      ST_SETTLE: begin
        if (tmr_expire) state_d = ST_SAMPLE;
      end
      ST_SAMPLE: begin
        if (mismatch) begin
          err_d = err_q + 1'b1;
          if (err_q == '0) fail_d = vec_q;
`ifdef GATE_CHK_STOP_ON_FAIL_EN
          finish = 1'b1;
`endif
        end
        if (vec_q == LAST_VEC) finish = 1'b1;
        if (finish) begin
          state_d = ST_DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          pass_d  = (err_d == '0);
        end else begin
          vec_d = vec_q + 1'b1;
          if (SETTLE == 0) state_d = ST_SAMPLE;
          else             state_d = ST_SETTLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and result registers; reset abandons any sweep in progress.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      vec_q   <= '0;
      err_q   <= '0;
      fail_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      vec_q   <= vec_d;
      err_q   <= err_d;
      fail_q  <= fail_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
    end
  end

  assign chk.dut_in    = vec_q;
  assign chk.busy      = busy_q;
  assign chk.done      = done_q;
  assign chk.pass      = pass_q;
  assign chk.err_count = err_q;
  assign chk.fail_vec  = fail_q;

endmodule
